value_display_seq: RTL

//  Sequential, parametrised signed-value-to-7-segment driver; next generation of the combinational display path.

---
 rtl/display_pkg.sv | 16 +
 rtl/bcd_to_seg7.sv | 14 +
 rtl/value_display_seq.sv | 127 ++++++++++++
 3 files changed

// File: rtl/display_pkg.sv
// Shared 7-segment definitions for the display path: active-low {g..a} codes, digit LUT and FSM states.
package display_pkg;

  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG_OFF   = 7'h7F;
  localparam seg7_t SEG_MINUS = 7'b011_1111;

  localparam seg7_t SEG_LUT [10] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

endpackage

// File: rtl/bcd_to_seg7.sv
// One BCD digit to active-low 7-segment pattern; non-decimal codes are dark.
module bcd_to_seg7
  import display_pkg::*;
(
  input  logic [3:0] digit,
  output seg7_t      seg
);

  always_comb begin
    seg = SEG_OFF;
    if (digit <= 4'd9) seg = SEG_LUT[digit];
  end

endmodule

// File: rtl/value_display_seq.sv
// Iterative double-dabble value-to-7-segment driver with load/busy/valid handshake and
// double-buffered outputs (previous result held until a new one completes).
module value_display_seq
  import display_pkg::*;
#(
  parameter int unsigned VALUE_W   = 16,
  parameter int unsigned DIGITS    = 5,
  parameter int unsigned IS_SIGNED = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [VALUE_W-1:0]    value,
  input  logic                  load,
  input  logic                  blank,
  output logic                  busy,
  output logic                  valid,
  output logic                  overflow,
  output logic [DIGITS:0][6:0]  hex_out
);

  localparam int unsigned SR_W  = 4 * DIGITS + VALUE_W;
  localparam int unsigned CNT_W = $clog2(VALUE_W + 1);

  state_e                 state_q, state_d;
  logic [SR_W-1:0]        sr_q, sr_d, adj;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   ovf_q, ovf_d;
  logic                   sign_q, sign_d;
  logic [DIGITS:0][6:0]   hex_q, hex_d, disp;
  logic                   ovf_out_q, ovf_out_d;
  logic                   valid_q, valid_d;
  logic [VALUE_W-1:0]     mag;
  seg7_t                  dig_seg [DIGITS];

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_to_seg7 u_seg (
      .digit (sr_q[VALUE_W + 4*g +: 4]),
      .seg   (dig_seg[g])
    );
  end

  // Display image of the finished conversion, with leading-zero blanking above digit 0.
  always_comb begin
    logic nz;
    nz   = 1'b0;
    disp = {(DIGITS + 1){SEG_OFF}};
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      nz = nz | (sr_q[VALUE_W + 4*i +: 4] != 4'd0);
      if (ovf_q)            disp[i] = SEG_MINUS;
      else if (nz || i == 0) disp[i] = dig_seg[i];
    end
    disp[DIGITS] = sign_q ? SEG_MINUS : SEG_OFF;
  end

  always_comb begin
    adj = sr_q;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (adj[VALUE_W + 4*i +: 4] >= 4'd5) adj[VALUE_W + 4*i +: 4] = adj[VALUE_W + 4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    sign_d    = sign_q;
    hex_d     = hex_q;
    ovf_out_d = ovf_out_q;
    valid_d   = 1'b0;
    mag       = value;
    unique case (state_q)
      StIdle: begin
        if (load) begin
          sign_d = (IS_SIGNED != 0) && value[VALUE_W-1];
          // Unsigned negate keeps the most negative value exact.
          if (sign_d) mag = ~value + 1'b1;
          sr_d    = {{(4 * DIGITS){1'b0}}, mag};
          cnt_d   = CNT_W'(VALUE_W);
          ovf_d   = 1'b0;
          state_d = StShift;
        end
      end
      StShift: begin
        sr_d  = {adj[SR_W-2:0], 1'b0};
        ovf_d = ovf_q | adj[SR_W-1];
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = StDone;
      end
      StDone: begin
        hex_d     = disp;
        ovf_out_d = ovf_q;
        valid_d   = 1'b1;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      sr_q      <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      sign_q    <= 1'b0;
      hex_q     <= {(DIGITS + 1){SEG_OFF}};
      ovf_out_q <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      sign_q    <= sign_d;
      hex_q     <= hex_d;
      ovf_out_q <= ovf_out_d;
      valid_q   <= valid_d;
    end
  end

  assign busy     = (state_q != StIdle);
  assign valid    = valid_q;
  assign overflow = ovf_out_q;
  assign hex_out  = blank ? {(DIGITS + 1){SEG_OFF}} : hex_q;

endmodule
